// File: rtl/priority_req_pkg.sv
// Shared types, defaults and helpers for priority_req_buffer.
// The entry record payload is sized by DEFAULT_WIDTH, so WIDTH must not exceed it.
package priority_req_pkg;
  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_CNT     = 5;
  localparam int DEFAULT_AGE_MAX = 15;

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } req_entry_t;

  function automatic int age_width(input int age_max);
    return (age_max < 1) ? 1 : $clog2(age_max + 1);
  endfunction
endpackage

// File: rtl/priority_req_buffer_first_one.sv
// Lowest-set-bit one-hot finder; used for the grant and for starved-entry selection.
module priority_first_one #(
  parameter int CNT = 5
) (
  input  logic [CNT-1:0] req,
  output logic [CNT-1:0] grant
);
  // Two's complement isolates the lowest set bit; yields zero when req is zero.
  assign grant = req & (~req + CNT'(1));
endmodule

// File: rtl/priority_req_buffer.sv
// Per-source request holding stage feeding priority_mux; retires the winner on out_ack.
// Optional aging build: define PRIORITY_REQ_BUFFER_AGING_EN.
module priority_req_buffer
  import priority_req_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CNT     = DEFAULT_CNT,
  parameter int AGE_MAX = DEFAULT_AGE_MAX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT-1:0]       in_valid,
  input  logic [WIDTH*CNT-1:0] in_data,
  output logic [CNT-1:0]       in_ready,
  output logic [WIDTH*CNT-1:0] din,
  output logic [CNT-1:0]       sel,
  output logic                 out_valid,
  input  logic                 out_ack
);
  req_entry_t     ent_q [CNT];
  logic [CNT-1:0] sel_q;
  logic [CNT-1:0] sel_d;
  logic [CNT-1:0] valid_q;
  logic [CNT-1:0] valid_d;
  logic [CNT-1:0] grant;
  logic [CNT-1:0] pop;
  logic [CNT-1:0] accept;

  for (genvar i = 0; i < CNT; i++) begin : g_ent
    assign valid_q[i]               = ent_q[i].valid;
    assign din[i*WIDTH +: WIDTH]    = WIDTH'(ent_q[i].data);
  end

  priority_first_one #(.CNT(CNT)) u_grant (
    .req   (sel_q),
    .grant (grant)
  );

  assign pop      = grant & {CNT{out_ack}};
  assign in_ready = {CNT{rst_n}} & (~valid_q | pop);
  assign accept   = in_valid & in_ready;
  assign valid_d  = accept | (valid_q & ~pop);

`ifdef PRIORITY_REQ_BUFFER_AGING_EN
  localparam int AW = age_width(AGE_MAX);
  localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

  logic [AW-1:0]  age_q [CNT];
  logic [AW-1:0]  age_d [CNT];
  logic [CNT-1:0] starved_d;
  logic [CNT-1:0] starved_pick;

  // Ages count only while an entry waits; a pop or an empty slot restarts at zero.
  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      age_d[i]     = '0;
      if (valid_q[i] && !pop[i])
        age_d[i] = (age_q[i] == AGE_LIM) ? AGE_LIM : age_q[i] + AW'(1);
      starved_d[i] = valid_d[i] && (age_d[i] == AGE_LIM);
    end
  end

  priority_first_one #(.CNT(CNT)) u_starve (
    .req   (starved_d),
    .grant (starved_pick)
  );

  assign sel_d = (|starved_d) ? starved_pick : valid_d;

  always_ff @(posedge clk) begin
    for (int i = 0; i < CNT; i++) begin
      if (!rst_n) age_q[i] <= '0;
      else        age_q[i] <= age_d[i];
    end
  end
`else
  assign sel_d = valid_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= '0;
      for (int i = 0; i < CNT; i++) ent_q[i] <= '0;
    end else begin
      sel_q <= sel_d;
      for (int i = 0; i < CNT; i++) begin
        ent_q[i].valid <= valid_d[i];
        if (accept[i]) ent_q[i].data <= DEFAULT_WIDTH'(in_data[i*WIDTH +: WIDTH]);
      end
    end
  end

  assign sel       = sel_q;
  assign out_valid = |sel_q;
endmodule

// File: tb/tb_priority_req_buffer.sv
// Self-checking bench for priority_req_buffer: queue-free per-source model plus directed literal checks.
module tb_priority_req_buffer;
  localparam int WIDTH   = 32;
  localparam int CNT     = 5;
  localparam int AGE_MAX = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [CNT-1:0]       in_valid = '0;
  logic [WIDTH*CNT-1:0] in_data = '0;
  logic                 out_ack = 1'b0;
  logic [CNT-1:0]       in_ready;
  logic [WIDTH*CNT-1:0] din;
  logic [CNT-1:0]       sel;
  logic                 out_valid;

  priority_req_buffer #(.WIDTH(WIDTH), .CNT(CNT), .AGE_MAX(AGE_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .din       (din),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit               m_valid [CNT];
  logic [WIDTH-1:0] m_data  [CNT];
  int               m_age   [CNT];
  logic [CNT-1:0]   m_sel;

  task automatic check(input string name, input logic [WIDTH*CNT-1:0] act,
                       input logic [WIDTH*CNT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [CNT-1:0] v);
    for (int i = 0; i < CNT; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [CNT-1:0] exp_ready();
    logic [CNT-1:0] r;
    int w;
    w = lowest(m_sel);
    for (int i = 0; i < CNT; i++)
      r[i] = (rst_n === 1'b1) && (!m_valid[i] || (out_ack === 1'b1 && w == i));
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [CNT-1:0] rdy;
    int w;
    int sv;
    bit popped;
    rdy = exp_ready();
    w   = lowest(m_sel);
    if (rst_n !== 1'b1) begin
      for (int i = 0; i < CNT; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
        m_age[i]   = 0;
      end
      m_sel = '0;
      return;
    end
    for (int i = 0; i < CNT; i++) begin
      popped = (out_ack === 1'b1) && (w == i);
      if (m_valid[i] && !popped) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
      else                       m_age[i] = 0;
      if (in_valid[i] && rdy[i]) begin
        m_valid[i] = 1'b1;
        m_data[i]  = in_data[i*WIDTH +: WIDTH];
      end else if (popped) begin
        m_valid[i] = 1'b0;
      end
    end
    sv = -1;
`ifdef PRIORITY_REQ_BUFFER_AGING_EN
    for (int i = 0; i < CNT; i++)
      if (sv < 0 && m_valid[i] && m_age[i] == AGE_MAX) sv = i;
`endif
    m_sel = '0;
    if (sv >= 0) m_sel[sv] = 1'b1;
    else for (int i = 0; i < CNT; i++) m_sel[i] = m_valid[i];
  endtask

  // One clock: model takes the edge, then new inputs are applied and all outputs compared.
  task automatic cycle(input logic [CNT-1:0] v, input logic [WIDTH*CNT-1:0] d,
                       input logic ack, input logic rst);
    logic [WIDTH*CNT-1:0] md;
    @(posedge clk);
    model_step();
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    out_ack  = ack;
    rst_n    = rst;
    #1;
    for (int i = 0; i < CNT; i++) md[i*WIDTH +: WIDTH] = m_data[i];
    check("model_sel", sel, m_sel);
    check("model_din", din, md);
    check("model_in_ready", in_ready, exp_ready());
    check("model_out_valid", out_valid, |m_sel);
  endtask

  function automatic logic [WIDTH*CNT-1:0] pk(input logic [WIDTH-1:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  logic [CNT-1:0]       exp_sel;
  logic [CNT-1:0]       rv;
  logic [WIDTH*CNT-1:0] rd;

  initial begin
    // reset
    cycle('0, '0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0);
    check("rst_sel", sel, 5'b00000);
    check("rst_din", din, '0);
    check("rst_in_ready", in_ready, 5'b00000);
    check("rst_out_valid", out_valid, 1'b0);

    // fill all five, then retire in priority order
    cycle(5'b11111, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4), 1'b0, 1'b1);
    check("fill_in_ready", in_ready, 5'b11111);
    cycle('0, '0, 1'b0, 1'b1);
    check("fill_sel", sel, 5'b11111);
    check("fill_din0", din[WIDTH-1:0], 32'hA0);
    for (int k = 0; k < 6; k++) begin
      cycle('0, '0, (k < 5), 1'b1);
      exp_sel = 5'b11111 << k;
      check("retire_sel", sel, exp_sel);
    end

    // source 2 streams while winning every cycle
    for (int j = 0; j < 8; j++) begin
      cycle(5'b00100, pk(0, 0, 32'(32'hB0 + j), 0, 0), 1'b1, 1'b1);
      check("stream_ready2", in_ready[2], 1'b1);
      if (j > 0) begin
        check("stream_sel", sel, 5'b00100);
        check("stream_din2", din[2*WIDTH +: WIDTH], 32'(32'hB0 + j - 1));
      end
    end
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
    check("stream_drained", sel, 5'b00000);

    // held entry 3 back-pressures a new payload
    cycle(5'b01000, pk(0, 0, 0, 32'hC3, 0), 1'b0, 1'b1);
    cycle(5'b01000, pk(0, 0, 0, 32'hC4, 0), 1'b0, 1'b1);
    check("hold_ready3", in_ready[3], 1'b0);
    cycle('0, '0, 1'b0, 1'b1);
    check("hold_din3", din[3*WIDTH +: WIDTH], 32'hC3);
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);

    // ack while empty is ignored
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    check("idle_ack_sel", sel, 5'b00000);
    check("idle_ack_ready", in_ready, 5'b11111);
    cycle(5'b00010, pk(0, 32'hD1, 0, 0, 0), 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
    check("post_idle_sel", sel, 5'b00010);
    check("post_idle_din1", din[WIDTH +: WIDTH], 32'hD1);
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);

`ifdef PRIORITY_REQ_BUFFER_AGING_EN
    // source 4 starves behind a constantly refilled source 0
    cycle(5'b10001, pk(32'hE0, 0, 0, 0, 32'hE4), 1'b1, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      cycle(5'b00001, pk(32'(32'hF0 + j), 0, 0, 0, 0), 1'b1, 1'b1);
      if (j < 5) check("age_wait_sel", sel, 5'b10001);
      if (j == 5) check("age_starved_sel", sel, 5'b10000);
      if (j == 6) check("age_resume_sel", sel, 5'b00001);
    end
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
`endif

    // reset with three entries held
    cycle(5'b00111, pk(32'h11, 32'h22, 32'h33, 0, 0), 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0);
    check("mid_rst_ready_now", in_ready, 5'b00000);
    cycle('0, '0, 1'b0, 1'b0);
    check("mid_rst_sel", sel, 5'b00000);
    check("mid_rst_din", din, '0);
    check("mid_rst_ready", in_ready, 5'b00000);
    cycle('0, '0, 1'b0, 1'b1);
    check("rel_ready", in_ready, 5'b11111);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rv = CNT'($urandom());
      for (int i = 0; i < CNT; i++) rd[i*WIDTH +: WIDTH] = $urandom();
      cycle(rv, rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
